// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring); divide hardware only with MULDIV_DIV_EN.
// Latency: fixed WIDTH+2 cycles from start sampled to done, independent of operand values.
// Backpressure: none; start is ignored unless IDLE, result/div_by_zero hold until next done or clear.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               last;
  logic               op_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH:0]   acc;
  logic               booth_q;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH:0]   acc_nxt;
  logic [2*WIDTH-1:0] fix_result;
  logic               fix_dbz;

  assign last  = (cnt == CW'(WIDTH - 1));
  // Hi half carries one guard bit so subtracting the most-negative multiplicand cannot wrap.
  assign a_ext = {a_q[WIDTH-1], a_q};

  always_comb begin
    hi_sum = acc[2*WIDTH:WIDTH];
    case ({acc[0], booth_q})
      2'b10:   hi_sum = acc[2*WIDTH:WIDTH] - a_ext;
      2'b01:   hi_sum = acc[2*WIDTH:WIDTH] + a_ext;
      default: hi_sum = acc[2*WIDTH:WIDTH];
    endcase
    acc_nxt = {hi_sum[WIDTH], hi_sum, acc[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   quo, dvs;
  logic [WIDTH+1:0]   rem;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH+1:0]   dvs_ext, rem_sh, rem_nxt;
  logic [WIDTH-1:0]   rem_fix, rem_sgn, quo_sgn;

  // Unsigned W-bit magnitudes: the most-negative value maps to 2^(W-1), which still fits.
  assign a_mag   = a[WIDTH-1] ? (0 - a) : a;
  assign b_mag   = b[WIDTH-1] ? (0 - b) : b;
  assign dvs_ext = {2'b00, dvs};
  assign rem_sh  = {rem[WIDTH:0], quo[WIDTH-1]};
  assign rem_nxt = rem[WIDTH+1] ? (rem_sh + dvs_ext) : (rem_sh - dvs_ext);
  assign rem_fix = rem[WIDTH+1] ? (rem[WIDTH-1:0] + dvs) : rem[WIDTH-1:0];
  assign quo_sgn = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (0 - quo) : quo;
  assign rem_sgn = a_q[WIDTH-1] ? (0 - rem_fix) : rem_fix;
`endif

  always_comb begin
    fix_result = acc[2*WIDTH-1:0];
    fix_dbz    = 1'b0;
    if (op_q) begin
`ifdef MULDIV_DIV_EN
      if (b_q == '0) begin
        fix_result = {a_q, {WIDTH{1'b1}}};
        fix_dbz    = 1'b1;
      end else begin
        fix_result = {rem_sgn, quo_sgn};
      end
`else
      fix_result = '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef MULDIV_DIV_EN
      IDLE: if (start) state_nxt = op ? DIV : MUL;
      DIV:  if (last)  state_nxt = FIX;
`else
      IDLE: if (start) state_nxt = MUL;
`endif
      MUL:  if (last)  state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL) || (state == DIV) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      result      <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q     <= a;
          op_q    <= op;
          cnt     <= '0;
          acc     <= {{(WIDTH+1){1'b0}}, b};
          booth_q <= 1'b0;
`ifdef MULDIV_DIV_EN
          b_q     <= b;
          quo     <= a_mag;
          dvs     <= b_mag;
          rem     <= '0;
`endif
        end
        MUL: begin
          acc     <= acc_nxt;
          booth_q <= acc[0];
          cnt     <= cnt + 1'b1;
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
          cnt <= cnt + 1'b1;
        end
`endif
        FIX: begin
          result      <= fix_result;
          div_by_zero <= fix_dbz;
        end
        default: ;
      endcase
    end
  end

endmodule
